// File: rtl/bp_update_scheduler.sv
// Branch predictor table write-port owner: resolves EX branches, raises flush/redirect,
// queues counter/target updates and arbitrates the single write port against a clear sweep.
//
// state | meaning
// IDLE  | no sweep; pop and apply queued updates, clear_req starts a sweep
// CLEAR | sweeping every table entry to target 0 / counter 01, FIFO held
// DRAIN | sweep finished with updates still queued; apply them, clear_req may restart sweep
module bp_update_scheduler #(
  parameter int ENTRIES = 128,
  parameter int IDX_W   = 7,
  parameter int FIFO_D  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_target,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic              ex_ready,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [IDX_W-1:0]  tbl_rd_idx,
  input  logic [1:0]        tbl_rd_ctr,
  output logic              tbl_we,
  output logic [IDX_W-1:0]  tbl_wr_idx,
  output logic [31:0]       tbl_wr_target,
  output logic [1:0]        tbl_wr_ctr,
  output logic [31:0]       br_count,
  output logic [31:0]       mispred_count
);

  localparam int PTR_W = $clog2(FIFO_D);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   q_idx    [FIFO_D];
  logic               q_taken  [FIFO_D];
  logic [31:0]        q_target [FIFO_D];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic [IDX_W-1:0]   sweep_idx;

  logic               fifo_empty, fifo_full;
  logic               acc, mispred, pop, hazard;
  logic [IDX_W-1:0]   head_idx;
  logic               head_taken;
  logic [31:0]        head_target;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign ex_ready    = !fifo_full;
  assign acc         = ex_valid & ex_is_branch & ex_ready;
  assign mispred     = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));

  assign head_idx    = q_idx[rd_ptr[PTR_W-1:0]];
  assign head_taken  = q_taken[rd_ptr[PTR_W-1:0]];
  assign head_target = q_target[rd_ptr[PTR_W-1:0]];
  assign tbl_rd_idx  = head_idx;

  // Counter read is stale while a write to the same entry is still on the port.
  assign hazard = tbl_we && (tbl_wr_idx == head_idx);
  assign pop    = (state != CLEAR) && !clear_req && !fifo_empty && !hazard;

  always_ff @(posedge clock) begin
    if (acc) begin
      q_idx[wr_ptr[PTR_W-1:0]]    <= ex_pc[IDX_W+1:2];
      q_taken[wr_ptr[PTR_W-1:0]]  <= ex_taken;
      q_target[wr_ptr[PTR_W-1:0]] <= ex_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sweep_idx     <= '0;
      flush         <= 1'b0;
      redirect_pc   <= 32'd0;
      clear_busy    <= 1'b0;
      tbl_we        <= 1'b0;
      tbl_wr_idx    <= '0;
      tbl_wr_target <= 32'd0;
      tbl_wr_ctr    <= 2'b00;
      br_count      <= 32'd0;
      mispred_count <= 32'd0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      flush       <= acc & mispred;
      redirect_pc <= (acc & mispred) ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'd0;
      if (acc && (br_count != 32'hFFFF_FFFF))
        br_count <= br_count + 32'd1;
      if (acc && mispred && (mispred_count != 32'hFFFF_FFFF))
        mispred_count <= mispred_count + 32'd1;

      tbl_we <= 1'b0;
      case (state)
        IDLE, DRAIN: begin
          if (clear_req) begin
            state      <= CLEAR;
            sweep_idx  <= '0;
            clear_busy <= 1'b1;
          end else begin
            if (pop) begin
              tbl_we        <= 1'b1;
              tbl_wr_idx    <= head_idx;
              tbl_wr_target <= head_target;
              tbl_wr_ctr    <= head_taken ? sat_inc(tbl_rd_ctr) : sat_dec(tbl_rd_ctr);
            end
            if (state == DRAIN && fifo_empty) state <= IDLE;
          end
        end
        CLEAR: begin
          tbl_we        <= 1'b1;
          tbl_wr_idx    <= sweep_idx;
          tbl_wr_target <= 32'd0;
          tbl_wr_ctr    <= 2'b01;
          sweep_idx     <= sweep_idx + 1'b1;
          if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
            clear_busy <= 1'b0;
            state      <= (fifo_empty && !acc) ? IDLE : DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: behavioural table, scoreboard of expected
// table writes built at issue time, checked against the write port as it fires.
module tb_bp_update_scheduler;

  localparam int ENTRIES = 128;
  localparam int IDX_W   = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0]       ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic              ex_ready, flush, clear_req = 1'b0, clear_busy, tbl_we;
  logic [31:0]       redirect_pc, tbl_wr_target, br_count, mispred_count;
  logic [IDX_W-1:0]  tbl_rd_idx, tbl_wr_idx;
  logic [1:0]        tbl_rd_ctr, tbl_wr_ctr;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [31:0]      tgt;
    logic [1:0]       ctr;
  } upd_t;

  upd_t        sb[$];
  logic [1:0]  tbl_ctr [ENTRIES];
  logic [31:0] tbl_tgt [ENTRIES];
  logic [1:0]  model_ctr [ENTRIES];
  int          errors = 0, checks = 0;
  int          clr_expect = 0, clr_next = 0, busy_cnt = 0;
  logic        busy_prev = 1'b0;
  logic [31:0] exp_br = 0, exp_mis = 0;

  always #5 clock = ~clock;

  bp_update_scheduler #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .FIFO_D(4)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_ready(ex_ready), .flush(flush),
    .redirect_pc(redirect_pc), .clear_req(clear_req), .clear_busy(clear_busy),
    .tbl_rd_idx(tbl_rd_idx), .tbl_rd_ctr(tbl_rd_ctr), .tbl_we(tbl_we),
    .tbl_wr_idx(tbl_wr_idx), .tbl_wr_target(tbl_wr_target), .tbl_wr_ctr(tbl_wr_ctr),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  // Behavioural predictor table; combinational counter read.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_ctr[i] <= 2'b01;
        tbl_tgt[i] <= 32'd0;
      end
    end else if (tbl_we) begin
      tbl_ctr[tbl_wr_idx] <= tbl_wr_ctr;
      tbl_tgt[tbl_wr_idx] <= tbl_wr_target;
    end
  end
  assign tbl_rd_ctr = tbl_ctr[tbl_rd_idx];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: sweep writes first, then queued updates in issue order.
  always @(negedge clock) begin
    if (!reset) begin
      busy_cnt  = 0;
      busy_prev = 1'b0;
    end else begin
      if (clear_busy) busy_cnt++;
      else if (busy_prev) begin
        check("clear_busy_len", 32'(busy_cnt), ENTRIES);
        busy_cnt = 0;
      end
      busy_prev = clear_busy;
      if (tbl_we) begin
        if (clr_expect > 0) begin
          check("sweep_idx", 32'(tbl_wr_idx), 32'(clr_next));
          check("sweep_tgt", tbl_wr_target, 32'd0);
          check("sweep_ctr", 32'(tbl_wr_ctr), 32'd1);
          clr_next++;
          clr_expect--;
        end else if (sb.size() > 0) begin
          upd_t e;
          e = sb.pop_front();
          check("upd_idx", 32'(tbl_wr_idx), 32'(e.idx));
          check("upd_tgt", tbl_wr_target, e.tgt);
          check("upd_ctr", 32'(tbl_wr_ctr), 32'(e.ctr));
        end else begin
          check("unexpected_write", 32'(tbl_we), 32'd0);
        end
      end
    end
  end

  function automatic logic [1:0] m_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction
  function automatic logic [1:0] m_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
    int n = 0;
    logic mis;
    logic [IDX_W-1:0] idx;
    upd_t e;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    while (!ex_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      check("ex_ready_timeout", 32'(ex_ready), 32'd1);
      ex_valid = 1'b0;
      return;
    end
    idx = pc[IDX_W+1:2];
    mis = (tk != ptk) || (tk && (tgt != ptgt));
    model_ctr[idx] = tk ? m_inc(model_ctr[idx]) : m_dec(model_ctr[idx]);
    e.idx = idx; e.tgt = tgt; e.ctr = model_ctr[idx];
    sb.push_back(e);
    exp_br++;
    if (mis) exp_mis++;
    @(posedge clock);
    #1 ex_valid = 1'b0;
    @(negedge clock);
    check("flush", 32'(flush), 32'(mis));
    if (mis) check("redirect_pc", redirect_pc, tk ? tgt : pc + 32'd4);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() > 0 || clr_expect > 0) && n < 600) begin
      @(negedge clock);
      n++;
    end
    check("drain_done", 32'(sb.size() + clr_expect), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic start_clear();
    clear_req = 1'b1;
    clr_expect = ENTRIES;
    clr_next = 0;
    for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 2'b01;
    @(posedge clock);
    #1 clear_req = 1'b0;
    @(negedge clock);
    check("clear_busy_on", 32'(clear_busy), 32'd1);
  endtask

  task automatic check_counts();
    check("br_count", br_count, exp_br);
    check("mispred_count", mispred_count, exp_mis);
  endtask

  task automatic check_reset_state();
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_tbl_we", 32'(tbl_we), 32'd0);
    check("rst_wr_idx", 32'(tbl_wr_idx), 32'd0);
    check("rst_wr_tgt", tbl_wr_target, 32'd0);
    check("rst_wr_ctr", 32'(tbl_wr_ctr), 32'd0);
    check("rst_br_count", br_count, 32'd0);
    check("rst_mis_count", mispred_count, 32'd0);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 2'b01;
    repeat (3) @(negedge clock);
    check_reset_state();
    reset = 1'b1;
    @(negedge clock);

    // Taken branch predicted not-taken; write lands two cycles after accept.
    send(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    check("lat_no_write_yet", 32'(tbl_we), 32'd0);
    @(negedge clock);
    check("lat_write", 32'(tbl_we), 32'd1);
    check("lat_idx", 32'(tbl_wr_idx), 32'h10);
    check("lat_ctr", 32'(tbl_wr_ctr), 32'd2);

    send(32'h44, 1'b0, 32'h200, 1'b1, 32'h200);
    send(32'h80, 1'b1, 32'h300, 1'b1, 32'h300);
    send(32'hFFFF_FFFC, 1'b0, 32'h500, 1'b1, 32'h500);
    send(32'h84, 1'b1, 32'h900, 1'b1, 32'h904);

    // Non-branch and invalid instructions are ignored.
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_taken = 1'b1; ex_pred_taken = 1'b0;
    @(posedge clock);
    #1 ex_valid = 1'b0; ex_is_branch = 1'b1;
    @(negedge clock);
    check("nonbranch_flush", 32'(flush), 32'd0);
    @(posedge clock);
    #1 ex_is_branch = 1'b0;
    @(negedge clock);
    check("invalid_flush", 32'(flush), 32'd0);
    wait_idle();
    check_counts();

    // Sweep with branches arriving mid-sweep; FIFO fills and holds them.
    start_clear();
    send(32'h100, 1'b1, 32'hA00, 1'b0, 32'h0);
    send(32'h104, 1'b0, 32'hA04, 1'b0, 32'h0);
    send(32'h108, 1'b1, 32'hA08, 1'b1, 32'hA08);
    send(32'h10C, 1'b1, 32'hA0C, 1'b1, 32'h0);
    check("full_ex_ready", 32'(ex_ready), 32'd0);
    check("full_busy", 32'(clear_busy), 32'd1);
    send(32'h110, 1'b0, 32'hA10, 1'b1, 32'hA10);
    wait_idle();
    check_counts();
    check("swept_ctr", 32'(tbl_ctr[5]), 32'd1);
    check("swept_tgt", tbl_tgt[5], 32'd0);

    // Counter saturation at a single entry, back-to-back same index.
    for (int i = 0; i < 4; i++) send(32'h2F0, 1'b1, 32'hB00, 1'b1, 32'hB00);
    for (int i = 0; i < 4; i++) send(32'h2F0, 1'b0, 32'hB00, 1'b0, 32'hB00);
    wait_idle();
    check("sat_final_ctr", 32'(tbl_ctr[8'h3C]), 32'd0);
    check_counts();

    // Reset in the middle of a sweep with updates queued.
    start_clear();
    repeat (33) @(negedge clock);
    send(32'h120, 1'b1, 32'hC00, 1'b0, 32'h0);
    send(32'h124, 1'b1, 32'hC04, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    clr_expect = 0;
    exp_br = 0;
    exp_mis = 0;
    for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 2'b01;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("post_rst_busy", 32'(clear_busy), 32'd0);
    check("post_rst_ready", 32'(ex_ready), 32'd1);
    check_counts();

    // Normal operation resumes after reset.
    send(32'h40, 1'b0, 32'h100, 1'b0, 32'h0);
    wait_idle();
    check_counts();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
